uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with built-in baud generator and transmit FIFO. Runs entirely in the system clock domain;
//  there is no derived baud clock. Producers push words with a valid/ready handshake; the block serialises them as
//  start / data (LSB first) / optional parity / stop bits on tx. Replaces fixed 8N1 transmitters in board top levels.
// PARAMETERS
//  CLK_HZ     12000000  system clock frequency in Hz
//  BAUD       9600      line rate; CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, must be >= 4 (1250 at defaults)
//  DATA_BITS  8         data bits per frame, 5..9
//  PARITY     0         0 = none, 1 = odd, 2 = even
//  STOP_BITS  1         1 or 2
//  FIFO_DEPTH 16        FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1                     system clock, all logic on posedge
//  rst        in   1                     asynchronous, active-high reset
//  s_data     in   DATA_BITS             word to transmit
//  s_valid    in   1                     s_data valid
//  s_ready    out  1                     FIFO can accept; = !full, combinational from registered state
//  tx         out  1                     serial line, idle high, registered
//  busy       out  1                     1 while a frame is on the line (FSM not IDLE)
//  tx_done    out  1                     one-cycle pulse on the last cycle of the final stop bit
//  fifo_level out  $clog2(FIFO_DEPTH)+1  words currently queued (excludes the frame in flight)
// BEHAVIOUR
//  Reset (async assert, any time incl. mid-frame): tx=1, busy=0, tx_done=0, fifo_level=0, s_ready=1, FSM=IDLE, baud
//   counter=0, FIFO emptied. A frame in flight is aborted; the line returns high immediately.
//  Push: s_valid && s_ready at a posedge writes s_data. s_valid while full is ignored: no write, no error.
//   Producer holds s_data until accepted.
//  Pop: FIFO is first-word-fall-through. FSM pops when in IDLE with !empty, or on the last cycle of the final stop bit
//   with !empty. Push and pop in one cycle: both happen, level unchanged.
//  Latency: word accepted at edge k into empty FIFO with FSM IDLE -> tx low from edge k+1. fifo_level returns to 0 at k+1.
//  FSM states:
//   IDLE   -> START on pop
//   START  -> DATA
//   DATA   repeats DATA_BITS times -> PARITY if PARITY!=0, else STOP
//   PARITY -> STOP
//   STOP   repeats STOP_BITS times -> START if !empty (pop same cycle, zero idle gap), else IDLE
//  Bit timing: each state/bit lasts exactly CLKS_PER_BIT cycles. Baud counter counts 0..CLKS_PER_BIT-1 and is forced
//   to 0 on entry to START, so the frame is aligned to the pop, not to a free-running tick.
//  Frame register loaded at pop; the FIFO entry may be overwritten afterwards without affecting the frame.
//  Parity: even = XOR of the DATA_BITS data bits; odd = its inverse.
//  tx_done asserts together with the STOP->IDLE/START transition cycle. busy is high from the first START cycle to
//   that same cycle inclusive.
// STRUCTURE
//  Shared package uart_pkg: PARITY_NONE/ODD/EVEN constants, FSM state encoding, function clks_per_bit(CLK_HZ,BAUD).
//  One sub-module: sync_fifo_fwft (WIDTH, DEPTH) with wr_en, rd_en, full, empty, level. Pointers carry one extra
//   wrap bit. Empty when pointers equal; full when only the wrap bit differs.
//  Top holds baud counter, bit counter, shift register, parity accumulator and FSM.
// TESTING (sim params CLK_HZ=1000000, BAUD=100000 -> 10 clk/bit unless stated)
//  1. 8N1, push 0x55 into idle block -> tx low at k+1; bits 1,0,1,0,1,0,1,0 at 10 clk each; 10 clk high;
//     tx_done pulse at clk 100 after start.
//  2. 7E2, push 0x41 -> 7 data bits 1000001, parity bit 0, two stop bits; frame = 110 clk.
//     PARITY=1 with same data -> parity bit 1.
//  3. Burst of 20 words with s_valid held, DEPTH 16 -> s_ready low after 16 queued + 1 in flight; frames contiguous,
//     no idle cycle between stop and next start; all 20 received in order.
//  4. Full FIFO: simultaneous pop and push -> level stays 16, no word lost or duplicated.
//  5. Assert rst at bit 3 of a frame -> tx high within the same cycle, fifo_level 0, busy 0. After release, a new push
//     transmits normally.
//  6. Defaults (12 MHz, 9600) -> CLKS_PER_BIT = 1250; measured bit width 1250 clk on every bit.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity codes, transmitter FSM encoding and baud divisor helper
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
    // Rounded clock-cycles-per-bit divisor.
    function automatic int clks_per_bit(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud / 2) / baud);
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO with occupancy count
//   clk, rst          clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    write request, ignored while full
//   rd_en, rd_data    read request, ignored while empty; rd_data shows the head whenever !empty
//   full, empty       status from the registered pointers
//   level             number of stored entries
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_wr, do_rd;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    // Pointers carry an extra wrap bit: equal means empty, only the wrap bit differing means full.
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_wr);
            rd_ptr <= rd_ptr + PW'(do_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with integrated baud timing and a FWFT transmit FIFO
//   clk         system clock, everything on posedge
//   rst         asynchronous active-high reset; aborts a frame in flight and empties the FIFO
//   s_data      word to transmit, accepted on s_valid && s_ready
//   s_valid     s_data valid
//   s_ready     FIFO not full
//   tx          serial line, idle high
//   busy        a frame is on the line
//   tx_done     pulse on the last cycle of the final stop bit
//   fifo_level  words queued, excluding the frame being sent
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         tx,
    output logic                         busy,
    output logic                         tx_done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int CPB     = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW      = $clog2(CPB);
    localparam int BW      = $clog2(DATA_BITS);
    localparam bit PAR_EN  = PARITY == PARITY_ODD || PARITY == PARITY_EVEN;
    localparam bit PAR_ODD = PARITY == PARITY_ODD;
    state_t state;
    logic [CW-1:0] baud_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg, fifo_data;
    logic par, par_next;
    logic full, empty, pop, bit_end, pre_end, last_data, last_stop;
    assign bit_end   = baud_cnt == CW'(CPB - 1);
    assign pre_end   = baud_cnt == CW'(CPB - 2);
    assign last_data = bit_cnt == BW'(DATA_BITS - 1);
    assign last_stop = bit_cnt == BW'(STOP_BITS - 1);
    assign par_next  = par ^ shreg[0];
    // Pop from idle, or at the very end of the final stop bit so back-to-back frames have no gap.
    assign pop       = !empty && (state == ST_IDLE || (state == ST_STOP && last_stop && bit_end));
    assign busy      = state != ST_IDLE;
    assign s_ready   = !full;
    sync_fifo_fwft #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (s_valid),
        .wr_data(s_data),
        .rd_en  (pop),
        .rd_data(fifo_data),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            // Held at zero while idle so every frame is timed from its own pop.
            baud_cnt <= (state == ST_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            // Registered one cycle early so the pulse lands on the last stop cycle.
            tx_done  <= state == ST_STOP && last_stop && pre_end;
            if (pop) begin
                state   <= ST_START;
                shreg   <= fifo_data;
                bit_cnt <= '0;
                par     <= 1'b0;
                tx      <= 1'b0;
            end else if (bit_end) begin
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                    ST_DATA: begin
                        shreg   <= shreg >> 1;
                        par     <= par_next;
                        bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
                        state   <= !last_data ? ST_DATA : PAR_EN ? ST_PARITY : ST_STOP;
                        tx      <= !last_data ? shreg[1] : PAR_EN ? par_next ^ PAR_ODD : 1'b1;
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                    ST_STOP: begin
                        state   <= last_stop ? ST_IDLE : ST_STOP;
                        bit_cnt <= bit_cnt + 1'b1;
                        tx      <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo against a per-cycle line model
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic drv_valid = 1'b0;
    logic [8:0] drv_data = '0;
    int sel = 0;
    int pushed = 0;
    int errors = 0;
    int checks = 0;
    logic [3:0] txs, busys, dones, readys;
    logic [4:0] levels [4];
    logic v_tx, v_busy, v_done, v_ready;
    logic [4:0] v_level;
    // instance configs: 0=8N1, 1=7E2, 2=7O2 (all 10 clk/bit), 3=defaults (1250 clk/bit)
    int cfg_db [4]  = '{8, 7, 7, 8};
    int cfg_par [4] = '{0, 2, 1, 0};
    int cfg_sb [4]  = '{1, 2, 2, 1};
    int cfg_cpb [4] = '{10, 10, 10, 1250};

    always #5 clk = ~clk;

    assign v_tx    = txs[sel];
    assign v_busy  = busys[sel];
    assign v_done  = dones[sel];
    assign v_ready = readys[sel];
    assign v_level = levels[sel];

    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .clk(clk), .rst(rst), .s_data(drv_data[7:0]), .s_valid(drv_valid && sel == 0), .s_ready(readys[0]),
        .tx(txs[0]), .busy(busys[0]), .tx_done(dones[0]), .fifo_level(levels[0]));
    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7e2 (
        .clk(clk), .rst(rst), .s_data(drv_data[6:0]), .s_valid(drv_valid && sel == 1), .s_ready(readys[1]),
        .tx(txs[1]), .busy(busys[1]), .tx_done(dones[1]), .fifo_level(levels[1]));
    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7o2 (
        .clk(clk), .rst(rst), .s_data(drv_data[6:0]), .s_valid(drv_valid && sel == 2), .s_ready(readys[2]),
        .tx(txs[2]), .busy(busys[2]), .tx_done(dones[2]), .fifo_level(levels[2]));
    uart_tx_fifo u_def (
        .clk(clk), .rst(rst), .s_data(drv_data[7:0]), .s_valid(drv_valid && sel == 3), .s_ready(readys[3]),
        .tx(txs[3]), .busy(busys[3]), .tx_done(dones[3]), .fifo_level(levels[3]));

    // Line level of bit position idx within one frame (0 = start bit).
    function automatic logic exp_bit(input logic [8:0] d, input int db, input int par, input int idx);
        logic p;
        p = 1'b0;
        if (idx == 0) return 1'b0;
        if (idx <= db) return d[idx-1];
        if (par != 0 && idx == db + 1) begin
            for (int i = 0; i < db; i++) p = p ^ d[i];
            return par == 1 ? !p : p;
        end
        return 1'b1;
    endfunction

    // Expected {tx, busy, tx_done} per cycle for contiguous frames, plus one idle cycle after.
    function automatic void build_exp(input logic [8:0] w[$], input int s, output logic [2:0] q[$]);
        int flen;
        int cyc;
        flen = 1 + cfg_db[s] + (cfg_par[s] != 0 ? 1 : 0) + cfg_sb[s];
        cyc = flen * cfg_cpb[s];
        q = {};
        foreach (w[j])
            for (int c = 0; c < cyc; c++)
                q.push_back({exp_bit(w[j], cfg_db[s], cfg_par[s], c / cfg_cpb[s]), 1'b1, c == cyc - 1});
        q.push_back(3'b100);
    endfunction

    task automatic capture(input int n, output logic [2:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) begin
            q.push_back({v_tx, v_busy, v_done});
            @(negedge clk);
        end
    endtask

    // Push words in order, honouring s_ready sampled between edges; starts on a negedge.
    task automatic produce(input logic [8:0] w[$]);
        int idx = 0;
        int guard = 0;
        logic acc;
        pushed = 0;
        while (idx < w.size() && guard < 20000) begin
            drv_data = w[idx];
            drv_valid = 1'b1;
            acc = v_ready;
            @(negedge clk);
            guard++;
            if (acc) begin
                idx++;
                pushed = idx;
            end
        end
        drv_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (v_tx !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (v_tx !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: tx=%b after 5000 cycles, required 0", name, v_tx);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (txs[i] !== 1'b1 || busys[i] !== 1'b0 || dones[i] !== 1'b0 || readys[i] !== 1'b1 || levels[i] !== 5'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: tx=%b busy=%b done=%b ready=%b level=%0d, required 1 0 0 1 0",
                         i, txs[i], busys[i], dones[i], readys[i], levels[i]);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (txs[i] !== 1'b1 || busys[i] !== 1'b0 || dones[i] !== 1'b0 || levels[i] !== 5'd0) begin
                errors++;
                $display("FAIL idle_after_reset inst%0d: tx=%b busy=%b done=%b level=%0d, required 1 0 0 0",
                         i, txs[i], busys[i], dones[i], levels[i]);
            end
        end
    endtask

    task automatic test_8n1;
        logic [8:0] w[$];
        logic [2:0] exp_q[$], obs[$];
        logic [15:0] got;
        int mis = 0;
        int first = -1;
        sel = 0;
        w = '{9'h55};
        @(negedge clk);
        drv_data = 9'h55;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        checks++;
        if (v_level !== 5'd1 || v_tx !== 1'b1 || v_busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_edge: level=%0d tx=%b busy=%b, required 1 1 0", v_level, v_tx, v_busy);
        end
        @(negedge clk);
        checks++;
        if (v_level !== 5'd0 || v_tx !== 1'b0 || v_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: level=%0d tx=%b busy=%b, required 0 0 1", v_level, v_tx, v_busy);
        end
        build_exp(w, 0, exp_q);
        capture(exp_q.size(), obs);
        foreach (exp_q[i]) if (obs[i] !== exp_q[i]) begin mis++; if (first < 0) first = i; end
        checks++;
        if (mis != 0) begin
            errors++;
            $display("FAIL 8n1_frame: %0d cycles differ, first at %0d got %b required %b", mis, first, obs[first], exp_q[first]);
        end
        got = '0;
        for (int b = 0; b < 10; b++) got[b] = obs[b * 10 + 5][2];
        checks++;
        if (got !== 16'h02AA) begin
            errors++;
            $display("FAIL 8n1_bits: got %h required 02aa", got);
        end
    endtask

    task automatic test_parity(input int s, input logic [15:0] want, input string name);
        logic [8:0] w[$];
        logic [2:0] exp_q[$], obs[$];
        logic [15:0] got;
        int mis = 0;
        int first = -1;
        sel = s;
        w = '{9'h41};
        @(negedge clk);
        drv_data = 9'h41;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (v_tx !== 1'b0 || v_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: tx=%b busy=%b, required 0 1", name, v_tx, v_busy);
        end
        build_exp(w, s, exp_q);
        capture(exp_q.size(), obs);
        foreach (exp_q[i]) if (obs[i] !== exp_q[i]) begin mis++; if (first < 0) first = i; end
        checks++;
        if (mis != 0) begin
            errors++;
            $display("FAIL %s_frame: %0d cycles differ, first at %0d got %b required %b", name, mis, first, obs[first], exp_q[first]);
        end
        got = '0;
        for (int b = 0; b < 11; b++) got[b] = obs[b * 10 + 5][2];
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s_bits: got %h required %h", name, got, want);
        end
    endtask

    task automatic test_random(input int s, input int n);
        logic [8:0] w[$];
        logic [2:0] exp_q[$], obs[$];
        int mis = 0;
        int first = -1;
        sel = s;
        for (int i = 0; i < n; i++) w.push_back(9'($urandom_range(0, (1 << cfg_db[s]) - 1)));
        build_exp(w, s, exp_q);
        @(negedge clk);
        fork
            produce(w);
            begin
                wait_start("random");
                capture(exp_q.size(), obs);
            end
        join
        foreach (exp_q[i]) if (obs[i] !== exp_q[i]) begin mis++; if (first < 0) first = i; end
        checks++;
        if (mis != 0) begin
            errors++;
            $display("FAIL random_frames inst%0d: %0d cycles differ, first at %0d got %b required %b", s, mis, first, obs[first], exp_q[first]);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] w[$];
        logic [2:0] exp_q[$], obs[$];
        int mis = 0;
        int first = -1;
        int low_at = -1;
        int lvl_at_18 = -1;
        int max_lvl = 0;
        sel = 0;
        for (int i = 0; i < 20; i++) w.push_back(9'($urandom_range(0, 255)));
        build_exp(w, 0, exp_q);
        @(negedge clk);
        fork
            produce(w);
            begin
                wait_start("burst");
                capture(exp_q.size(), obs);
            end
            begin
                for (int i = 0; i < 600; i++) begin
                    @(negedge clk);
                    #1;
                    if (int'(v_level) > max_lvl) max_lvl = int'(v_level);
                    if (v_ready === 1'b0 && low_at < 0) low_at = pushed;
                    if (pushed == 18 && lvl_at_18 < 0) lvl_at_18 = int'(v_level);
                end
            end
        join
        foreach (exp_q[i]) if (obs[i] !== exp_q[i]) begin mis++; if (first < 0) first = i; end
        checks++;
        if (mis != 0) begin
            errors++;
            $display("FAIL burst_frames: %0d cycles differ, first at %0d got %b required %b", mis, first, obs[first], exp_q[first]);
        end
        checks++;
        if (low_at != 17) begin
            errors++;
            $display("FAIL burst_ready_low: ready fell after %0d accepted words, required 17", low_at);
        end
        checks++;
        if (max_lvl != 16) begin
            errors++;
            $display("FAIL burst_max_level: %0d, required 16", max_lvl);
        end
        checks++;
        if (lvl_at_18 != 16) begin
            errors++;
            $display("FAIL full_refill_level: %0d, required 16", lvl_at_18);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [8:0] w[$];
        logic [2:0] exp_q[$], obs[$];
        int mis = 0;
        int first = -1;
        sel = 0;
        @(negedge clk);
        produce('{9'h0F0, 9'h03C, 9'h099});
        repeat (34) @(negedge clk);
        checks++;
        if (v_tx !== 1'b0 || v_level !== 5'd2 || v_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: tx=%b level=%0d busy=%b, required 0 2 1", v_tx, v_level, v_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (v_tx !== 1'b1 || v_level !== 5'd0 || v_busy !== 1'b0 || v_ready !== 1'b1 || v_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset: tx=%b level=%0d busy=%b ready=%b done=%b, required 1 0 0 1 0",
                     v_tx, v_level, v_busy, v_ready, v_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w = '{9'h0C3};
        build_exp(w, 0, exp_q);
        fork
            produce(w);
            begin
                wait_start("post_reset");
                capture(exp_q.size(), obs);
            end
        join
        foreach (exp_q[i]) if (obs[i] !== exp_q[i]) begin mis++; if (first < 0) first = i; end
        checks++;
        if (mis != 0) begin
            errors++;
            $display("FAIL post_reset_frame: %0d cycles differ, first at %0d got %b required %b", mis, first, obs[first], exp_q[first]);
        end
    endtask

    task automatic test_defaults;
        logic [8:0] w[$];
        logic [2:0] exp_q[$], obs[$];
        int mis = 0;
        int first = -1;
        int run = 0;
        sel = 3;
        w = '{9'($urandom_range(0, 255)) | 9'h001};
        build_exp(w, 3, exp_q);
        @(negedge clk);
        fork
            produce(w);
            begin
                wait_start("default");
                capture(exp_q.size(), obs);
            end
        join
        foreach (exp_q[i]) if (obs[i] !== exp_q[i]) begin mis++; if (first < 0) first = i; end
        checks++;
        if (mis != 0) begin
            errors++;
            $display("FAIL default_frame: %0d cycles differ, first at %0d got %b required %b", mis, first, obs[first], exp_q[first]);
        end
        while (run < obs.size() && obs[run][2] === 1'b0) run++;
        checks++;
        if (run != 1250) begin
            errors++;
            $display("FAIL default_start_width: %0d clk, required 1250", run);
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity(1, 16'h0682, "7e2");
        test_parity(2, 16'h0782, "7o2");
        test_random(1, 4);
        test_random(2, 4);
        test_back_to_back;
        test_reset_mid_frame;
        test_defaults;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "timeout");
    end
endmodule
